alu_arbiter: RTL
================

# alu_arbiter

Two-requester, round-robin arbiter and sequencer that shares the single combinational 32-bit ALU between requester A and requester B. It accepts one operation at a time over a valid/ready handshake and drives the ALU from registered operands. It captures the ALU result and zero flag, and returns them with a requester ID over a valid/ready response channel. It sits between the ALU and the units that issue arithmetic work to it.

## Interface
Parameters:
- DW, 32, operand/result width; must match the ALU (32)
- OPW, 4, ALU operation code width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ_A_VALID  in  1  requester A has an operation
- REQ_A_READY  out  1  A's operation is accepted this cycle
- REQ_A_OP1 / REQ_A_OP2  in  DW  A operands
- REQ_A_OP  in  OPW  A operation code
- REQ_B_VALID, REQ_B_READY, REQ_B_OP1, REQ_B_OP2, REQ_B_OP: same for B
- ALU_OP1 / ALU_OP2  out  DW  operands to ALU
- ALU_OP  out  OPW  operation code to ALU
- ALU_OPS  in  DW  ALU result
- ALU_ZF  in  1  ALU zero flag
- RSP_VALID  out  1  response available
- RSP_READY  in  1  consumer takes response
- RSP_ID  out  1  0 = A, 1 = B
- RSP_OPS  out  DW  result
- RSP_ZF  out  1  zero flag
- RSP_ERR  out  1  operation rejected (unsupported code or divide by zero)

## Operation
- FSM states:
  - IDLE → EXEC on an accepted request.
  - EXEC → RESP unconditionally after one cycle.
  - RESP → IDLE when RSP_VALID && RSP_READY.
- Arbitration in IDLE (REQ_x_READY is combinational):
  - Only A valid: A granted.
  - Only B valid: B granted.
  - Both valid: grant the requester other than LAST, where LAST is the last-granted ID.
  - REQ_x_READY = IDLE && grant==x. At most one READY is high. Both are low outside IDLE.
- On acceptance:
  - Latch OP1, OP2, OP and ID into internal registers.
  - Set LAST = granted ID.
- ALU drive:
  - ALU_OP1/ALU_OP2 always equal the latched operands.
  - ALU_OP equals the latched code in EXEC, and 4'b0110 (zero op) in every other state.
- Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLT (unsigned), 0101 DIV (unsigned), 0110 ZERO, 0111 MUL (low 32 bits), 1111 XOR.
- Capture at the end of EXEC:
  - Codes 1000–1110: RSP_ERR=1, RSP_OPS=0, RSP_ZF=0.
  - Code 0101 with OP2==0: RSP_ERR=1, RSP_OPS=0, RSP_ZF=0.
  - Otherwise: RSP_OPS=ALU_OPS, RSP_ZF=ALU_ZF, RSP_ERR=0.
  - RSP_ID = latched ID.
- RESP: RSP_VALID=1; RSP_ID/OPS/ZF/ERR are held stable until the handshake.
- Request side: once REQ_x_VALID is raised, the requester holds it and the payload stable until REQ_x_READY.

## Timing
- Reset (asynchronous, immediate), all outputs low/zero:
  - State IDLE, LAST=1 so A wins the first tie.
  - Latched operands/code/ID = 0.
  - ALU_OP1=ALU_OP2=0, ALU_OP=4'b0110.
  - RSP_VALID=0, RSP_ID=0, RSP_OPS=0, RSP_ZF=0, RSP_ERR=0.
  - REQ_A_READY=REQ_B_READY=0 until the first IDLE cycle after deassertion.
- Latency:
  - Cycle 0: handshake in IDLE.
  - Cycle 1: EXEC, ALU inputs stable for the full cycle.
  - Cycle 2: RSP_VALID=1.
- Throughput: if RSP_READY is high in cycle 2, cycle 3 is IDLE and can accept. Peak rate is one operation per 3 cycles.
- Response stall: RSP_READY low keeps the FSM in RESP indefinitely; no request is accepted while stalled.
- Fairness: under continuous dual VALID, grants alternate A, B, A, B…
- A request raised during EXEC or RESP waits; it is arbitrated in the next IDLE cycle.
- RST mid-operation: the in-flight operation is discarded and no response is produced. LAST returns to 1.

## Test plan
- Single op: A sends OP1=7, OP2=5, OP=0010 → REQ_A_READY in cycle 0; ALU_OP=0010 in cycle 1; cycle 2 RSP_VALID=1, RSP_ID=0, RSP_OPS=12, RSP_ZF=0, RSP_ERR=0.
- Round-robin: A and B both valid continuously with SUB 9-9 and OR 1|2 → grant order A, B, A, B after reset. Responses: ID0 OPS=0 ZF=1; ID1 OPS=3 ZF=0.
- Errors:
  - B sends DIV 10/0 → RSP_ID=1, RSP_ERR=1, RSP_OPS=0, RSP_ZF=0.
  - B sends code 1010 → same error response.
  - ALU_OP=0110 outside EXEC in both cases.
- Backpressure: hold RSP_READY=0 for 5 cycles after RSP_VALID → response fields unchanged, REQ_A_READY=REQ_B_READY=0 throughout. Raising RSP_READY lets the FSM return to IDLE next cycle.
- Reset mid-op: assert RST during EXEC of MUL 3*4 → outputs zero immediately, no RSP_VALID after release. The next request is accepted normally.
- Unsigned semantics: SLT with OP1=32'hFFFFFFFF, OP2=1 → RSP_OPS=0, ZF=1. MUL 32'h10000*32'h10000 → RSP_OPS=0, ZF=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational ALU
// between two requesters, with a registered response channel.
module alu_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           REQ_A_VALID,
  output logic           REQ_A_READY,
  input  logic [DW-1:0]  REQ_A_OP1,
  input  logic [DW-1:0]  REQ_A_OP2,
  input  logic [OPW-1:0] REQ_A_OP,
  input  logic           REQ_B_VALID,
  output logic           REQ_B_READY,
  input  logic [DW-1:0]  REQ_B_OP1,
  input  logic [DW-1:0]  REQ_B_OP2,
  input  logic [OPW-1:0] REQ_B_OP,
  output logic [DW-1:0]  ALU_OP1,
  output logic [DW-1:0]  ALU_OP2,
  output logic [OPW-1:0] ALU_OP,
  input  logic [DW-1:0]  ALU_OPS,
  input  logic           ALU_ZF,
  output logic           RSP_VALID,
  input  logic           RSP_READY,
  output logic           RSP_ID,
  output logic [DW-1:0]  RSP_OPS,
  output logic           RSP_ZF,
  output logic           RSP_ERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [OPW-1:0] OP_ZERO = OPW'(6);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(15);
  localparam logic [OPW-1:0] OP_LAST = OPW'(7);

  logic [1:0]     state_q, state_d;
  logic [DW-1:0]  op1_q, op1_d;
  logic [DW-1:0]  op2_q, op2_d;
  logic [OPW-1:0] op_q, op_d;
  logic           id_q, id_d;
  logic           last_q, last_d;
  logic [DW-1:0]  rsp_ops_q, rsp_ops_d;
  logic           rsp_zf_q, rsp_zf_d;
  logic           rsp_err_q, rsp_err_d;
  logic           rsp_id_q, rsp_id_d;

  logic idle;
  logic gnt_b;
  logic accept;
  logic bad_code;
  logic div_zero;
  logic err;

  // Grant selection; ready is held low while reset is asserted
  always_comb begin
    idle   = !RST && (state_q == S_IDLE);
    gnt_b  = REQ_B_VALID && (!REQ_A_VALID || !last_q);
    accept = idle && (REQ_A_VALID || REQ_B_VALID);
    REQ_A_READY = idle && REQ_A_VALID && !gnt_b;
    REQ_B_READY = idle && gnt_b;
  end

  // Rejected codes: 8..14 are unsupported, divide needs a nonzero divisor
  always_comb begin
    bad_code = (op_q > OP_LAST) && (op_q != OP_XOR);
    div_zero = (op_q == OP_DIV) && (op2_q == '0);
    err      = bad_code || div_zero;
  end

  // Next-state and capture logic
  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    op_d      = op_q;
    id_d      = id_q;
    last_d    = last_q;
    rsp_ops_d = rsp_ops_q;
    rsp_zf_d  = rsp_zf_q;
    rsp_err_d = rsp_err_q;
    rsp_id_d  = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_EXEC;
          op1_d   = gnt_b ? REQ_B_OP1 : REQ_A_OP1;
          op2_d   = gnt_b ? REQ_B_OP2 : REQ_A_OP2;
          op_d    = gnt_b ? REQ_B_OP : REQ_A_OP;
          id_d    = gnt_b;
          last_d  = gnt_b;
        end
      end
      S_EXEC: begin
        state_d   = S_RESP;
        rsp_ops_d = err ? '0 : ALU_OPS;
        rsp_zf_d  = err ? 1'b0 : ALU_ZF;
        rsp_err_d = err;
        rsp_id_d  = id_q;
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared immediately by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      op_q      <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      rsp_ops_q <= '0;
      rsp_zf_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      op_q      <= op_d;
      id_q      <= id_d;
      last_q    <= last_d;
      rsp_ops_q <= rsp_ops_d;
      rsp_zf_q  <= rsp_zf_d;
      rsp_err_q <= rsp_err_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  // ALU sees the real code only while executing
  always_comb begin
    ALU_OP1   = op1_q;
    ALU_OP2   = op2_q;
    ALU_OP    = (state_q == S_EXEC) ? op_q : OP_ZERO;
    RSP_VALID = (state_q == S_RESP);
    RSP_ID    = rsp_id_q;
    RSP_OPS   = rsp_ops_q;
    RSP_ZF    = rsp_zf_q;
    RSP_ERR   = rsp_err_q;
  end

endmodule
